param_updown_counter: RTL and testbench

Parametrised synchronous up/down counter of WIDTH bits with programmable modulus, parallel load, count enable and terminal-count output. It is the general-purpose successor to the single-bit toggle flip-flop stage in the counter library, and is used wherever a multi-bit divider, event counter or decade-style counter is needed. All state changes occur on the rising edge of C. Cascading uses TC into the next stage's EN.

---
 rtl/param_updown_counter_if.sv | 16 +
 rtl/param_updown_counter.sv | 86 ++++++++
 tb/tb_param_updown_counter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter: the master drives EN/UP/LD/D,
// the counter (slave) returns Q/Qn/TC.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             TC;

  modport master (output EN, UP, LD, D, input Q, Qn, TC);
  modport slave  (input EN, UP, LD, D, output Q, Qn, TC);
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load and terminal count.
// Define COUNTER_SATURATE_EN to make counting saturate at the range ends instead of wrapping.
module param_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 16
) (
  input  logic                  C,
  input  logic                  R,
  param_updown_counter_if.slave cnt
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ZERO_Q = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] load_q_s;

  // One count step; out-of-range values recover to 0 (up) or MAX_Q (down).
  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] q, input logic up);
    logic [WIDTH-1:0] r;
    if (up) begin
      if (q == MAX_Q) begin
`ifdef COUNTER_SATURATE_EN
        r = MAX_Q;
`else
        r = ZERO_Q;
`endif
      end else if (q > MAX_Q) begin
        r = ZERO_Q;
      end else begin
        r = q + ONE_Q;
      end
    end else begin
      if (q == ZERO_Q) begin
`ifdef COUNTER_SATURATE_EN
        r = ZERO_Q;
`else
        r = MAX_Q;
`endif
      end else if (q > MAX_Q) begin
        r = MAX_Q;
      end else begin
        r = q - ONE_Q;
      end
    end
    return r;
  endfunction

  // Load value clamped into the count range.
  always_comb begin
    load_q_s = cnt.D;
    if (cnt.D > MAX_Q) begin
      load_q_s = MAX_Q;
    end else begin
      load_q_s = cnt.D;
    end
  end

  // Next-state selection: load beats count beats hold; reset is applied in the register.
  always_comb begin
    next_q_s = q_r;
    if (cnt.LD) begin
      next_q_s = load_q_s;
    end else if (cnt.EN) begin
      next_q_s = step_f(q_r, cnt.UP);
    end else begin
      next_q_s = q_r;
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge C) begin
    if (R) begin
      q_r <= ZERO_Q;
    end else begin
      q_r <= next_q_s;
    end
  end

  assign cnt.Q  = q_r;
  assign cnt.Qn = ~q_r;
  assign cnt.TC = cnt.EN & ((cnt.UP & (q_r == MAX_Q)) | (~cnt.UP & (q_r == ZERO_Q)));

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4, MODULUS=10) plus a two-digit cascade.
module tb_param_updown_counter;

  logic C;
  logic R;
  logic cas_r;

  param_updown_counter_if #(.WIDTH(4)) cnt_if ();
  param_updown_counter_if #(.WIDTH(4)) lo_if ();
  param_updown_counter_if #(.WIDTH(4)) hi_if ();

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut    (.C(C), .R(R),     .cnt(cnt_if.slave));
  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (.C(C), .R(cas_r), .cnt(lo_if.slave));
  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (.C(C), .R(cas_r), .cnt(hi_if.slave));

  assign hi_if.EN = lo_if.TC;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  initial C = 1'b0;
  always #5 C = ~C;

  // Drive one vector on the falling edge and queue what the DUT must show after the next rising edge.
  task automatic drive(input logic r, input logic ld, input logic en, input logic up,
                       input logic [3:0] d, input logic [3:0] eq, input logic etc);
    exp_t e;
    @(negedge C);
    R         = r;
    cnt_if.LD = ld;
    cnt_if.EN = en;
    cnt_if.UP = up;
    cnt_if.D  = d;
    e.idx = vec_n;
    e.q   = eq;
    e.tc  = etc;
    sb_q.push_back(e);
    vec_n++;
    @(posedge C);
  endtask

  // Monitor: Q is valid 1 time unit after every rising edge; compare against the queued expectation.
  always @(posedge C) begin
    exp_t       e;
    logic [3:0] eqn;
    #1;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      eqn = ~e.q;
      checks++;
      if (cnt_if.Q !== e.q || cnt_if.Qn !== eqn || cnt_if.TC !== e.tc) begin
        errors++;
        $display("FAIL vec%0d: got Q=%h Qn=%h TC=%b, expected Q=%h Qn=%h TC=%b",
                 e.idx, cnt_if.Q, cnt_if.Qn, cnt_if.TC, e.q, eqn, e.tc);
      end
    end
  end

  initial begin
    int nines;
    R = 1'b0; cnt_if.LD = 1'b0; cnt_if.EN = 1'b0; cnt_if.UP = 1'b1; cnt_if.D = 4'd0;
    cas_r = 1'b0; lo_if.LD = 1'b0; lo_if.EN = 1'b0; lo_if.UP = 1'b1; lo_if.D = 4'd0;
    hi_if.LD = 1'b0; hi_if.UP = 1'b1; hi_if.D = 4'd0;

    // reset overrides load and enable
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
    // up count through the wrap
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] eq;
      eq = 4'((i % 10));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, eq, (eq == 4'd9));
    end
    // load 2, count down through the wrap
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0);
    // load priority over enable, clamp, reset over load
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd4,  4'd4, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  4'd0, 1'b1);
    // hold, then direction changes with no lost step
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 1'b0);
    // range ends: load 8 and count up, load 1 and count down
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd8, 1'b0);
`ifdef COUNTER_SATURATE_EN
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
`else
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0);
`endif
    // let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(posedge C);
    @(negedge C);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    // two-digit cascade, 100 edges up from 00
    cas_r = 1'b1;
    @(posedge C);
    @(negedge C);
    cas_r = 1'b0;
    lo_if.EN = 1'b1;
    nines = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge C);
      #1;
      if (lo_if.Q == 4'd9) nines++;
      if (i == 57) begin
        checks++;
        if ({hi_if.Q, lo_if.Q} !== 8'h57) begin
          errors++;
          $display("FAIL cascade_57: got %h%h, expected 57", hi_if.Q, lo_if.Q);
        end
      end
    end
    checks++;
    if ({hi_if.Q, lo_if.Q} !== 8'h00) begin
      errors++;
      $display("FAIL cascade_100: got %h%h, expected 00", hi_if.Q, lo_if.Q);
    end
    checks++;
    if (nines != 10) begin
      errors++;
      $display("FAIL cascade_nines: got %0d, expected 10", nines);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
